// File: rtl/uart_pkg.sv
// Shared definitions for the UART controller: receiver FSM encoding,
// default oversampling ratio, register map and status bit positions.
package uart_pkg;

    // Default number of baud-rate strobes per serial bit.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Receiver FSM encoding (kept as plain constants for legacy tools).
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Controller register map.
    localparam logic [7:0] ADDR_TX_DATA  = 8'h00;
    localparam logic [7:0] ADDR_STATUS   = 8'h01;
    localparam logic [7:0] ADDR_CTRL     = 8'h02;
    localparam logic [7:0] ADDR_BAUD_DIV = 8'h03;
    localparam logic [7:0] ADDR_RX_DATA  = 8'h04;

    // Status register bit positions.
    localparam int STAT_TXBUSY  = 0;
    localparam int STAT_RXFULL  = 1;
    localparam int STAT_FERR    = 2;
    localparam int STAT_OVERRUN = 3;

    // Status nibble as the controller presents it (bit 3 down to bit 0).
    typedef struct packed {
        logic overrun;
        logic ferr;
        logic rxfull;
        logic txbusy;
    } uart_status_t;

    // Two-out-of-three vote used by the input noise filter.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-controller data/status bundle. The controller is the master:
// it issues the read pulse and observes the received byte and flags.
interface uart_rx_if;
    logic       rd_i;
    logic [7:0] dout_o;
    logic       full_o;
    logic       frame_err_o;
    logic       overrun_o;

    modport master (
        output rd_i,
        input  dout_o, full_o, frame_err_o, overrun_o
    );

    modport slave (
        input  rd_i,
        output dout_o, full_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/uart_rx_filter.sv
// Conditions an asynchronous input: 2-flop synchroniser followed by a
// 3-sample majority vote whose history advances only on tick_i.
// Everything resets to 1 (the idle level of a serial line).
module uart_rx_filter
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rstn_i,
    input  logic tick_i,
    input  logic din_i,
    output logic dout_o
);

    logic sync1_q;
    logic sync2_q;
    logic [1:0] hist_q;

    // Bring the asynchronous input into the clock domain.
    // NOTE: non-blocking assignments here are what make sync1_q -> sync2_q a real
    // two-stage shift; blocking would collapse both flops into one.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

    // Keep the two previous tick-rate samples for the vote.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            hist_q <= 2'b11;
        end else if (tick_i) begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    // Current sample plus the two previous ones; a single-sample glitch is outvoted.
    assign dout_o = maj3(hist_q[1], hist_q[0], sync2_q);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Oversamples the line with the baud-rate strobe, frames
// characters, holds one byte for the controller and flags framing errors and
// overruns. OVERSAMPLE must be even and at least 4.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      brg_stb_i,
    input  logic      rx_i,
    uart_rx_if.slave  bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] TICK_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);

    logic          rx_bit;
    logic [2:0]    state_q;
    logic [CW-1:0] tick_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          accept;

    logic [7:0]    dout_q;
    logic          full_q;
    logic          ferr_q;
    logic          ovr_q;

    uart_rx_filter u_filter (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .tick_i (brg_stb_i),
        .din_i  (rx_i),
        .dout_o (rx_bit)
    );

    // Frame sequencer: advances only on baud strobes.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else if (brg_stb_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_q    <= ST_START;
                        tick_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    // Re-check mid start bit so a short low pulse is not taken as a frame.
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= rx_bit ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        shift_q    <= {rx_bit, shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_q <= '0;
                        state_q    <= rx_bit ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_cnt_q <= tick_cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A line held low must return high before a new start bit is accepted.
                    if (rx_bit) begin
                        state_q <= ST_IDLE;
                    end
                end
                // NOTE: unused encodings fall back to IDLE so an upset cannot wedge the FSM.
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Stop-bit sample tick: the byte in shift_q is complete.
    assign accept = brg_stb_i && (state_q == ST_STOP) && (tick_cnt_q == TICK_LAST);

    // Holding register and flags: runs every clock; a new byte beats a read.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dout_q <= '0;
            full_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else if (accept) begin
            if (!full_q || bus.rd_i) begin
                dout_q <= shift_q;
                full_q <= 1'b1;
                ferr_q <= ~rx_bit;
                ovr_q  <= ovr_q & ~bus.rd_i;
            end else begin
                ovr_q  <= 1'b1;
            end
        end else if (bus.rd_i) begin
            full_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end
    end

    assign bus.dout_o      = dout_q;
    assign bus.full_o      = full_q;
    assign bus.frame_err_o = ferr_q;
    assign bus.overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud strobe tied high, 16 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLKS = 16;

    logic clk_i     = 1'b0;
    logic rstn_i    = 1'b0;
    logic brg_stb_i = 1'b1;
    logic rx_i      = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .brg_stb_i (brg_stb_i),
        .rx_i      (rx_i),
        .bus       (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   rise_cyc  = -1;
    logic full_prev = 1'b0;

    // Free-running edge counter and first-rise capture of full_o.
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (bus.full_o && !full_prev && rise_cyc < 0) rise_cyc <= cyc;
        full_prev <= bus.full_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic f,
                             input logic fe, input logic ov);
        check({tag, "_dout"},  32'(bus.dout_o),      32'(d));
        check({tag, "_full"},  32'(bus.full_o),      32'(f));
        check({tag, "_ferr"},  32'(bus.frame_err_o), 32'(fe));
        check({tag, "_ovr"},   32'(bus.overrun_o),   32'(ov));
    endtask

    // Wait n rising edges, then step just past the edge.
    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx_i = v;
        clk_wait(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic pulse_rd();
        bus.rd_i = 1'b1;
        clk_wait(1);
        bus.rd_i = 1'b0;
    endtask

    int c0;
    int lat;
    int acc_lat;

    initial begin
        bus.rd_i = 1'b0;

        // Reset state
        clk_wait(3);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rstn_i = 1'b1;
        clk_wait(2);

        // Short low pulse: start bit rejected, nothing received
        rx_i = 1'b0;
        clk_wait(4);
        rx_i = 1'b1;
        clk_wait(40);
        check_all("glitch", 8'h00, 1'b0, 1'b0, 1'b0);

        // 0x75 with latency measurement, then read
        c0 = cyc;
        send_frame(8'h75, 1'b1);
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        lat = rise_cyc - c0;
        check("lat_in_154_156", 32'(lat >= 154 && lat <= 156), 32'd1);
        acc_lat = (lat >= 154 && lat <= 156) ? lat : 156;
        check_all("b75", 8'h75, 1'b1, 1'b0, 1'b0);
        pulse_rd();
        check("b75_rd_full", 32'(bus.full_o), 32'd0);
        check("b75_rd_dout", 32'(bus.dout_o), 32'h75);

        // 0xA5 with low stop bit and a held-low line (break)
        send_frame(8'hA5, 1'b0);
        clk_wait(3 * BIT_CLKS);
        rx_i = 1'b1;
        clk_wait(200);
        check_all("brk", 8'hA5, 1'b1, 1'b1, 1'b0);
        pulse_rd();
        check("brk_rd_full", 32'(bus.full_o), 32'd0);
        check("brk_rd_ferr", 32'(bus.frame_err_o), 32'd0);
        send_frame(8'h3C, 1'b1);
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        check_all("b3c", 8'h3C, 1'b1, 1'b0, 1'b0);
        pulse_rd();

        // Overrun: 0x11 then 0x22 without a read
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        check_all("ovr", 8'h11, 1'b1, 1'b0, 1'b1);
        pulse_rd();
        check_all("ovr_rd", 8'h11, 1'b0, 1'b0, 1'b0);

        // Read coinciding with the accept of the next byte
        send_frame(8'h11, 1'b1);
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        check("coin_pre_full", 32'(bus.full_o), 32'd1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                clk_wait(acc_lat - 1);
                bus.rd_i = 1'b1;
                clk_wait(1);
                bus.rd_i = 1'b0;
            end
        join
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        check_all("coin", 8'h22, 1'b1, 1'b0, 1'b0);

        // Reset during data bit 4 of 0x5A; sender abandons the frame too
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        rx_i = 1'b1;
        clk_wait(BIT_CLKS / 2);
        rstn_i = 1'b0;
        clk_wait(1);
        rstn_i = 1'b1;
        check_all("midrst", 8'h00, 1'b0, 1'b0, 1'b0);
        clk_wait(200);
        check_all("midrst_idle", 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1);
        rx_i = 1'b1;
        clk_wait(BIT_CLKS);
        check_all("bc3", 8'hC3, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
